// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter: one-hot grant, address-phase owner/lock tracking,
// unbroken fixed-length bursts and locked sequences, parking and a BUSY watchdog.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int BUSY_MAX       = 6
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic [NUM_MASTERS-1:0]         HBUSREQ,
    input  logic [NUM_MASTERS-1:0]         HLOCK,
    input  logic [1:0]                     HTRANS,
    input  logic [2:0]                     HBURST,
    input  logic                           HREADY,
    output logic [NUM_MASTERS-1:0]         HGRANT,
    output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
    output logic                           HMASTLOCK,
    output logic                           busy_err,
    output logic [1:0]                     o_dbg_state,
    output logic [3:0]                     o_dbg_beats
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int BUSY_W = $clog2(BUSY_MAX + 2);
    localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [BUSY_W-1:0]      BUSY_SAT  = BUSY_W'(BUSY_MAX + 1);
    localparam logic [BUSY_W-1:0]      BUSY_LIM  = BUSY_W'(BUSY_MAX);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {ST_PARK, ST_OWNED, ST_BURST, ST_LOCKED} state_t;

    state_t                  r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_rr_ptr, w_ptr_nxt;
    logic [NUM_MASTERS-1:0]  r_grant, w_grant_nxt;
    logic [IDX_W-1:0]        r_master;
    logic                    r_mastlock;
    logic [3:0]              r_beats, w_beats_nxt;
    logic [BUSY_W-1:0]       r_busy_cnt, w_busy_nxt;
    logic                    r_busy_err, w_busy_err_nxt;
    logic [IDX_W-1:0]        w_winner, w_idx;
    logic                    w_found;
    logic                    w_lock_req;

    // Remaining beats after the NONSEQ; INCR and SINGLE stay interruptible.
    function automatic logic [3:0] burst_beats(input logic [2:0] b);
        case (b)
            3'b010, 3'b011: burst_beats = 4'd3;
            3'b100, 3'b101: burst_beats = 4'd7;
            3'b110, 3'b111: burst_beats = 4'd15;
            default:        burst_beats = 4'd0;
        endcase
    endfunction

    // Round-robin search begins one past the current owner; owner is checked last.
    always_comb begin
        w_winner = r_rr_ptr;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_idx = IDX_W'((int'(r_rr_ptr) + i) % NUM_MASTERS);
            if (!w_found && HBUSREQ[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_beats_nxt = r_beats;
        if (HREADY) begin
            case (HTRANS)
                TR_NONSEQ: w_beats_nxt = burst_beats(HBURST);
                TR_SEQ:    w_beats_nxt = (r_beats != 4'd0) ? r_beats - 4'd1 : 4'd0;
                TR_IDLE:   w_beats_nxt = 4'd0;
                default:   w_beats_nxt = r_beats;
            endcase
        end
    end

    always_comb begin
        w_busy_nxt = '0;
        if (HTRANS == TR_BUSY)
            w_busy_nxt = (r_busy_cnt == BUSY_SAT) ? BUSY_SAT : r_busy_cnt + BUSY_W'(1);
        w_busy_err_nxt = r_busy_err | (w_busy_nxt > BUSY_LIM);
    end

    assign w_lock_req = HLOCK[r_rr_ptr] & HBUSREQ[r_rr_ptr];

    // Grant is frozen while locked or while beats remain after this edge.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_rr_ptr;
        if (HREADY) begin
            if (w_lock_req) begin
                w_state_nxt = ST_LOCKED;
            end else if (w_beats_nxt != 4'd0) begin
                w_state_nxt = (r_state == ST_LOCKED) ? ST_LOCKED : ST_BURST;
            end else if (w_found) begin
                w_state_nxt = ST_OWNED;
                w_ptr_nxt   = w_winner;
            end else begin
                w_state_nxt = ST_PARK;
                w_ptr_nxt   = DEF_IDX;
            end
        end
        w_grant_nxt            = '0;
        w_grant_nxt[w_ptr_nxt] = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= ST_PARK;
            r_rr_ptr   <= DEF_IDX;
            r_grant    <= DEF_GRANT;
            r_master   <= DEF_IDX;
            r_mastlock <= 1'b0;
            r_beats    <= 4'd0;
            r_busy_cnt <= '0;
            r_busy_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_beats    <= w_beats_nxt;
            r_busy_cnt <= w_busy_nxt;
            r_busy_err <= w_busy_err_nxt;
            if (HREADY) begin
                r_master   <= r_rr_ptr;
                r_mastlock <= HLOCK[r_rr_ptr];
            end
        end
    end

    assign HGRANT      = r_grant;
    assign HMASTER     = r_master;
    assign HMASTLOCK   = r_mastlock;
    assign busy_err    = r_busy_err;
    assign o_dbg_state = r_state;
    assign o_dbg_beats = r_beats;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: vector table for arbitration and bursts,
// hand sequences for lock, lock+burst, BUSY watchdog and mid-burst reset.
module tb_ahb_arbiter;

  localparam logic [1:0] ST_PARK = 2'd0, ST_OWNED = 2'd1, ST_BURST = 2'd2, ST_LOCKED = 2'd3;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic       clk;
  logic       rst;
  logic [3:0] busreq;
  logic [3:0] lock;
  logic [1:0] trans;
  logic [2:0] burst;
  logic       ready;
  logic [3:0] grant;
  logic [1:0] master;
  logic       mastlock;
  logic       berr;
  logic [1:0] dbg_state;
  logic [3:0] dbg_beats;

  int total;
  int bad;

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0), .BUSY_MAX(6)) dut (
    .HCLK(clk), .HRESET(rst), .HBUSREQ(busreq), .HLOCK(lock),
    .HTRANS(trans), .HBURST(burst), .HREADY(ready),
    .HGRANT(grant), .HMASTER(master), .HMASTLOCK(mastlock), .busy_err(berr),
    .o_dbg_state(dbg_state), .o_dbg_beats(dbg_beats)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       rdy;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] st;
    logic [3:0] bt;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rq, input logic [3:0] lk, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy);
    busreq = rq;
    lock   = lk;
    trans  = tr;
    burst  = bu;
    ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(4'b0000, 4'b0000, IDLE, 3'b000, 1'b1);

    //            req      tr      bu      rdy   g        m     st         bt
    vecs[0]  = '{4'b0110, IDLE,   3'b000, 1'b1, 4'b0010, 2'd0, ST_OWNED, 4'd0};
    vecs[1]  = '{4'b0010, IDLE,   3'b000, 1'b1, 4'b0010, 2'd1, ST_OWNED, 4'd0};
    vecs[2]  = '{4'b0100, IDLE,   3'b000, 1'b1, 4'b0100, 2'd1, ST_OWNED, 4'd0};
    vecs[3]  = '{4'b0000, IDLE,   3'b000, 1'b1, 4'b0001, 2'd2, ST_PARK,  4'd0};
    vecs[4]  = '{4'b1000, IDLE,   3'b000, 1'b0, 4'b0001, 2'd2, ST_PARK,  4'd0};
    vecs[5]  = '{4'b0010, IDLE,   3'b000, 1'b1, 4'b0010, 2'd0, ST_OWNED, 4'd0};
    vecs[6]  = '{4'b1010, NONSEQ, 3'b011, 1'b1, 4'b0010, 2'd1, ST_BURST, 4'd3};
    vecs[7]  = '{4'b1010, SEQ,    3'b011, 1'b0, 4'b0010, 2'd1, ST_BURST, 4'd3};
    vecs[8]  = '{4'b1010, SEQ,    3'b011, 1'b1, 4'b0010, 2'd1, ST_BURST, 4'd2};
    vecs[9]  = '{4'b1010, SEQ,    3'b011, 1'b1, 4'b0010, 2'd1, ST_BURST, 4'd1};
    vecs[10] = '{4'b1010, SEQ,    3'b011, 1'b1, 4'b1000, 2'd1, ST_OWNED, 4'd0};
    vecs[11] = '{4'b1000, IDLE,   3'b000, 1'b1, 4'b1000, 2'd3, ST_OWNED, 4'd0};
    vecs[12] = '{4'b1000, NONSEQ, 3'b100, 1'b1, 4'b1000, 2'd3, ST_BURST, 4'd7};
    vecs[13] = '{4'b1001, IDLE,   3'b000, 1'b1, 4'b0001, 2'd3, ST_OWNED, 4'd0};

    tick();
    tick();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'h1);
    chk("rst_master", 32'(master), 32'h0);
    chk("rst_mastlock", 32'(mastlock), 32'h0);
    chk("rst_busy_err", 32'(berr), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_PARK));
    chk("rst_beats", 32'(dbg_beats), 32'h0);

    // table: round-robin, park, stall hold, INCR4 with stall, early termination
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].req, 4'b0000, vecs[i].tr, vecs[i].bu, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].g));
      chk($sformatf("vec%0d_master", i), 32'(master), 32'(vecs[i].m));
      chk($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_beats", i), 32'(dbg_beats), 32'(vecs[i].bt));
      chk($sformatf("vec%0d_mastlock", i), 32'(mastlock), 32'h0);
    end

    // locked sequence on M2 while M0/M1 request
    drive(4'b0100, 4'b0000, IDLE, 3'b000, 1'b1);
    tick();
    chk("lk_pre_grant", 32'(grant), 32'h4);
    for (int i = 0; i < 6; i++) begin
      drive(4'b0111, 4'b0100, IDLE, 3'b000, 1'b1);
      tick();
      chk($sformatf("lk%0d_grant", i), 32'(grant), 32'h4);
      chk($sformatf("lk%0d_mastlock", i), 32'(mastlock), 32'h1);
      chk($sformatf("lk%0d_master", i), 32'(master), 32'h2);
      chk($sformatf("lk%0d_state", i), 32'(dbg_state), 32'(ST_LOCKED));
    end
    drive(4'b0011, 4'b0000, IDLE, 3'b000, 1'b1);
    tick();
    chk("lk_rel_grant", 32'(grant), 32'h1);
    chk("lk_rel_mastlock", 32'(mastlock), 32'h0);
    chk("lk_rel_state", 32'(dbg_state), 32'(ST_OWNED));

    // lock together with an INCR4: release needs both lock dropped and beats done
    drive(4'b0001, 4'b0001, NONSEQ, 3'b011, 1'b1);
    tick();
    chk("lb_state0", 32'(dbg_state), 32'(ST_LOCKED));
    chk("lb_beats0", 32'(dbg_beats), 32'h3);
    chk("lb_mastlock0", 32'(mastlock), 32'h1);
    for (int i = 1; i <= 2; i++) begin
      drive(4'b0011, 4'b0000, SEQ, 3'b011, 1'b1);
      tick();
      chk($sformatf("lb_state%0d", i), 32'(dbg_state), 32'(ST_LOCKED));
      chk($sformatf("lb_grant%0d", i), 32'(grant), 32'h1);
      chk($sformatf("lb_beats%0d", i), 32'(dbg_beats), 32'(3 - i));
    end
    tick();
    chk("lb_end_grant", 32'(grant), 32'h2);
    chk("lb_end_state", 32'(dbg_state), 32'(ST_OWNED));

    // BUSY watchdog: 6 cycles tolerated, 7th sets the sticky flag
    drive(4'b0010, 4'b0000, BUSY, 3'b000, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("busy6_err", 32'(berr), 32'h0);
    trans = SEQ;
    tick();
    trans = BUSY;
    for (int i = 0; i < 6; i++) tick();
    chk("busy7_pre_err", 32'(berr), 32'h0);
    tick();
    chk("busy7_err", 32'(berr), 32'h1);
    trans = SEQ;
    tick();
    tick();
    chk("busy_sticky", 32'(berr), 32'h1);

    // reset in the middle of an INCR8
    drive(4'b0010, 4'b0000, NONSEQ, 3'b101, 1'b1);
    tick();
    chk("r8_beats_load", 32'(dbg_beats), 32'h7);
    trans = SEQ;
    for (int i = 0; i < 3; i++) tick();
    chk("r8_beats_mid", 32'(dbg_beats), 32'h4);
    chk("r8_state_mid", 32'(dbg_state), 32'(ST_BURST));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r8_grant", 32'(grant), 32'h1);
    chk("r8_master", 32'(master), 32'h0);
    chk("r8_state", 32'(dbg_state), 32'(ST_PARK));
    chk("r8_beats", 32'(dbg_beats), 32'h0);
    chk("r8_busy_err", 32'(berr), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Multi-master AHB bus arbiter sharing one address/control path between NUM_MASTERS masters.
- Takes per-master HBUSREQ/HLOCK and the muxed HTRANS/HBURST/HREADY of the current owner.
- Drives one-hot HGRANT, HMASTER and HMASTLOCK; keeps fixed-length bursts and locked sequences unbroken.
- Parks the bus on a default master when idle and flags masters stuck in BUSY.

Parameters:
- NUM_MASTERS, 4: number of requesting masters (2..8).
- DEFAULT_MASTER, 0: index granted when no master requests (park).
- BUSY_MAX, 6: maximum consecutive BUSY cycles tolerated before busy_err.

Ports:
- HCLK  in  1  bus clock; everything is on its rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master lock request.
- HTRANS  in  2  current owner's transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HBURST  in  3  current owner's burst type.
- HREADY  in  1  bus-wide transfer-complete.
- HGRANT  out  NUM_MASTERS  one-hot grant.
- HMASTER  out  clog2(NUM_MASTERS)  index of the master owning the current address phase.
- HMASTLOCK  out  1  current address phase is locked.
- busy_err  out  1  sticky: BUSY held longer than BUSY_MAX.

Behaviour:
- Reset values:
  - HGRANT = one-hot(DEFAULT_MASTER), HMASTER = DEFAULT_MASTER.
  - HMASTLOCK = 0, busy_err = 0.
  - state = PARK, beat counter = 0, BUSY counter = 0, round-robin pointer = DEFAULT_MASTER.
- A reset mid-burst or mid-lock aborts the sequence and returns to these values on the next edge.
- All outputs are registered. HGRANT, HMASTER and HMASTLOCK update only on edges where HREADY=1 and hold otherwise.
- Address-phase ownership: on HREADY=1, HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index(HGRANT)]. HMASTER therefore lags HGRANT by one accepted cycle.
- Beat counter (4 bits, remaining beats):
  - Load on NONSEQ with HREADY=1: SINGLE(000)=0, INCR4/WRAP4=3, INCR8/WRAP8=7, INCR16/WRAP16=15.
  - Decrement on SEQ with HREADY=1 while nonzero.
  - BUSY and stalls (HREADY=0) do not decrement.
  - INCR (001) loads 0, so it is always interruptible.
- States:
  - PARK: default master granted, no requests.
  - OWNED: a requester is granted, re-arbitration permitted.
  - BURST: beat counter nonzero, grant frozen.
  - LOCKED: owner holds HLOCK=1 and HBUSREQ=1, grant frozen.
- Transitions (evaluated when HREADY=1):
  - Any state -> LOCKED when the owner asserts HLOCK and HBUSREQ.
  - LOCKED -> OWNED/PARK once the owner drops HLOCK and the beat counter is 0.
  - OWNED -> BURST on a NONSEQ with a fixed-length HBURST.
  - BURST -> OWNED when the counter reaches 0.
  - OWNED/PARK -> re-arbitrate.
- Arbitration is round-robin:
  - Search starts at (owner+1) mod NUM_MASTERS.
  - The first asserted HBUSREQ wins and the pointer moves to the winner.
  - The owner keeps the bus if it is the only requester.
  - No requests -> grant DEFAULT_MASTER and go to PARK.
- Handover costs zero extra cycles:
  - The new HGRANT is visible in the cycle after the last beat's address phase is accepted.
  - The old master's data phase completes under HMASTER until the next HREADY=1.
- Early burst termination: an IDLE or NONSEQ seen in BURST with HREADY=1 clears the counter to 0 (NONSEQ reloads it).
- BUSY watchdog:
  - The BUSY counter increments on every cycle HTRANS=BUSY and saturates.
  - Any non-BUSY HTRANS clears it.
  - busy_err sets when the count exceeds BUSY_MAX and clears only on HRESET.
- Simultaneous lock and burst: LOCKED takes precedence. The counter keeps running, and the lock is released only when both conditions clear.
- HGRANT is always exactly one-hot, including after reset.

Test Plan:
- Reset, no requests -> HGRANT=0001, HMASTER=0, HMASTLOCK=0, busy_err=0.
- HBUSREQ=0110 with owner 0, HREADY=1 -> grant moves to M1. Once M1 drops its request, grant moves to M2; once M2 drops, grant returns to M0.
- M1 issues NONSEQ INCR4, then 3 SEQ beats with HREADY toggling 1,0,1,1,1, while M3 requests -> HGRANT stays 0010 until the 3rd SEQ is accepted, then becomes 1000.
- M2 asserts HLOCK=1 and HBUSREQ=1 for 6 transfers while M0/M1 request -> HGRANT stays 0100 and HMASTLOCK=1 during those address phases. After HLOCK drops, the next arbitration grants M3→M0 by round-robin.
- HTRANS=BUSY for 7 consecutive cycles -> busy_err rises on the 7th and stays 1 after HTRANS returns to SEQ. With only 6 BUSY cycles, busy_err stays 0.
- HRESET asserted mid-INCR8 at beat 4 -> next edge: HGRANT=0001, beat counter 0, state PARK.
